// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Holds the arbiter FSM state and requester-id enums.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported synchronous memory.
// Ports: i_*/d_* request+response, d_lock, mem_* macro side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  input  logic        i_write_en,
  input  logic [3:0]  i_data_en,
  input  logic [31:0] i_data_i,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic        d_write_en,
  input  logic [3:0]  d_data_en,
  input  logic [31:0] d_data_i,
  input  logic        d_lock,
  output logic        i_resp_valid,
  output logic [31:0] i_resp_data,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic [31:0] mem_addr,
  output logic        mem_write_en,
  output logic [3:0]  mem_data_en,
  output logic [31:0] mem_data_i,
  input  logic [31:0] mem_data_o
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] starve_cnt, cnt_nxt;
  logic          i_pend, d_pend;
  logic          gnt_i, gnt_d, starved;
  req_id_t       win;

  // Grants are forced low while reset is held so the
  // macro sees no access during reset.
  always_comb begin
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    starved = (starve_cnt == LIM);
    if (!reset) begin
      unique case (state)
        ARB: begin
          gnt_d = d_valid && !(i_valid && starved);
          gnt_i = i_valid && !gnt_d;
        end
        LOCKED: gnt_d = d_valid;
        default: ;
      endcase
    end
  end

  assign i_ready = gnt_i;
  assign d_ready = gnt_d;
  assign win     = gnt_d ? REQ_D : REQ_I;

  always_comb begin
    mem_addr     = '0;
    mem_write_en = 1'b0;
    mem_data_en  = '0;
    mem_data_i   = '0;
    if (gnt_i || gnt_d) begin
      unique case (win)
        REQ_D: begin
          mem_addr     = d_addr;
          mem_write_en = d_write_en;
          mem_data_en  = d_data_en;
          mem_data_i   = d_data_i;
        end
        REQ_I: begin
          mem_addr     = i_addr;
          mem_write_en = i_write_en;
          mem_data_en  = i_data_en;
          mem_data_i   = i_data_i;
        end
        default: ;
      endcase
    end
  end

  // Counter freezes while locked: lock beats starvation.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    if (gnt_d) begin
      state_nxt = d_lock ? LOCKED : ARB;
    end
    if (state == ARB) begin
      if (!i_valid || gnt_i) begin
        cnt_nxt = '0;
      end else if (!starved) begin
        cnt_nxt = starve_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      i_pend     <= 1'b0;
      d_pend     <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
      i_pend     <= gnt_i;
      d_pend     <= gnt_d;
    end
  end

  assign i_resp_valid = i_pend;
  assign d_resp_valid = d_pend;
  assign i_resp_data  = i_pend ? mem_data_o : '0;
  assign d_resp_data  = d_pend ? mem_data_o : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small
// synchronous memory model on the mem_* side.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, i_ready, i_write_en;
  logic [31:0] i_addr, i_data_i;
  logic [3:0]  i_data_en;
  logic        d_valid, d_ready, d_write_en, d_lock;
  logic [31:0] d_addr, d_data_i;
  logic [3:0]  d_data_en;
  logic        i_resp_valid, d_resp_valid;
  logic [31:0] i_resp_data, d_resp_data;
  logic [31:0] mem_addr, mem_data_i, mem_data_o;
  logic        mem_write_en;
  logic [3:0]  mem_data_en;
  logic [31:0] mem [64];

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_addr(i_addr), .i_write_en(i_write_en),
    .i_data_en(i_data_en), .i_data_i(i_data_i),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_addr(d_addr), .d_write_en(d_write_en),
    .d_data_en(d_data_en), .d_data_i(d_data_i),
    .d_lock(d_lock),
    .i_resp_valid(i_resp_valid),
    .i_resp_data(i_resp_data),
    .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data),
    .mem_addr(mem_addr),
    .mem_write_en(mem_write_en),
    .mem_data_en(mem_data_en),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o)
  );

  always #5 clk = ~clk;

  // Word w powers up as 0x1000_0000 + w.
  always @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < 64; w++)
        mem[w] <= 32'h1000_0000 + 32'(w);
      mem_data_o <= '0;
    end else begin
      if (mem_write_en)
        for (int b = 0; b < 4; b++)
          if (mem_data_en[b])
            mem[mem_addr[7:2]][8*b +: 8] <=
              mem_data_i[8*b +: 8];
      mem_data_o <= mem[mem_addr[7:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " i_ready"}, 32'(i_ready), 0);
    chk({tag, " d_ready"}, 32'(d_ready), 0);
    chk({tag, " i_rv"}, 32'(i_resp_valid), 0);
    chk({tag, " d_rv"}, 32'(d_resp_valid), 0);
    chk({tag, " i_rd"}, i_resp_data, 0);
    chk({tag, " d_rd"}, d_resp_data, 0);
    chk({tag, " m_addr"}, mem_addr, 0);
    chk({tag, " m_we"}, 32'(mem_write_en), 0);
    chk({tag, " m_en"}, 32'(mem_data_en), 0);
    chk({tag, " m_di"}, mem_data_i, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    i_valid = 1'b1; i_addr = 32'h10;
    i_write_en = 0; i_data_en = 4'hF; i_data_i = 0;
    d_valid = 0; d_addr = 0; d_write_en = 0;
    d_data_en = 4'hF; d_data_i = 0; d_lock = 0;
    tick();
    tick();
    all_zero("rst");
    chk("rst state", 32'(dut.state), 32'(ARB));
    chk("rst cnt", 32'(dut.starve_cnt), 0);
    i_valid = 0;
    reset = 0;
    #1;
    all_zero("post_rst");

    // single fetch read
    i_valid = 1; i_addr = 32'h10;
    #1;
    chk("rd i_ready", 32'(i_ready), 1);
    chk("rd d_ready", 32'(d_ready), 0);
    chk("rd m_addr", mem_addr, 32'h10);
    tick();
    i_valid = 0;
    #1;
    chk("rd i_rv", 32'(i_resp_valid), 1);
    chk("rd i_rd", i_resp_data, 32'h1000_0004);
    chk("rd d_rv", 32'(d_resp_valid), 0);
    tick();
    chk("rd i_rv off", 32'(i_resp_valid), 0);
    chk("rd i_rd off", i_resp_data, 0);

    // idle
    for (int k = 0; k < 10; k++) begin
      chk("idle m_we", 32'(mem_write_en), 0);
      chk("idle m_en", 32'(mem_data_en), 0);
      chk("idle i_rv", 32'(i_resp_valid), 0);
      chk("idle d_rv", 32'(d_resp_valid), 0);
      chk("idle cnt", 32'(dut.starve_cnt), 0);
      tick();
    end

    // contention: d x4, then i, then d
    i_valid = 1; i_addr = 32'h10;
    d_valid = 1; d_addr = 32'h20;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("ct d_ready", 32'(d_ready), 32'(k != 4));
      chk("ct i_ready", 32'(i_ready), 32'(k == 4));
      tick();
      chk("ct i_rv", 32'(i_resp_valid), 32'(k == 4));
      chk("ct d_rv", 32'(d_resp_valid), 32'(k != 4));
      if (k == 4) begin
        chk("ct cnt clr", 32'(dut.starve_cnt), 0);
        chk("ct i_rd", i_resp_data, 32'h1000_0004);
      end
    end
    i_valid = 0; d_valid = 0;
    tick();
    chk("lk cnt0", 32'(dut.starve_cnt), 0);

    // lock with the counter saturated
    i_valid = 1; i_addr = 32'h10;
    d_valid = 1; d_addr = 32'h40;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("lk ramp d_ready", 32'(d_ready), 1);
      tick();
    end
    d_lock = 1;
    #1;
    chk("lk d_ready", 32'(d_ready), 1);
    chk("lk i_ready", 32'(i_ready), 0);
    tick();
    d_valid = 0; d_lock = 0;
    #1;
    chk("lk state", 32'(dut.state), 32'(LOCKED));
    chk("lk cnt sat", 32'(dut.starve_cnt), 4);
    chk("lk d_rv", 32'(d_resp_valid), 1);
    chk("lk d_rd", d_resp_data, 32'h1000_0010);
    for (int j = 0; j < 5; j++) begin
      chk("lk hold i_ready", 32'(i_ready), 0);
      chk("lk hold state", 32'(dut.state),
          32'(LOCKED));
      chk("lk hold m_we", 32'(mem_write_en), 0);
      tick();
    end
    d_valid = 1; d_write_en = 1; d_data_en = 4'hF;
    d_data_i = 32'hDEAD_BEEF; d_addr = 32'h40;
    #1;
    chk("ul d_ready", 32'(d_ready), 1);
    chk("ul i_ready", 32'(i_ready), 0);
    chk("ul m_we", 32'(mem_write_en), 1);
    chk("ul m_addr", mem_addr, 32'h40);
    chk("ul m_di", mem_data_i, 32'hDEAD_BEEF);
    tick();
    d_valid = 0; d_write_en = 0;
    #1;
    chk("ul state", 32'(dut.state), 32'(ARB));
    chk("ul d_rv", 32'(d_resp_valid), 1);
    chk("ul i_ready", 32'(i_ready), 1);
    chk("ul m_addr i", mem_addr, 32'h10);
    tick();
    i_valid = 0;
    #1;
    chk("ul i_rv", 32'(i_resp_valid), 1);
    chk("ul i_rd", i_resp_data, 32'h1000_0004);
    chk("ul d_rv off", 32'(d_resp_valid), 0);
    tick();

    // byte write then read back
    d_valid = 1; d_write_en = 1; d_data_en = 4'b0010;
    d_data_i = 32'h0000_AB00; d_addr = 32'h44;
    #1;
    chk("bw d_ready", 32'(d_ready), 1);
    chk("bw m_we", 32'(mem_write_en), 1);
    chk("bw m_en", 32'(mem_data_en), 32'h2);
    tick();
    d_write_en = 0; d_data_en = 4'hF;
    #1;
    chk("bw d_rv", 32'(d_resp_valid), 1);
    chk("bw rd m_we", 32'(mem_write_en), 0);
    tick();
    d_addr = 32'h40;
    #1;
    chk("bw rd d_rv", 32'(d_resp_valid), 1);
    chk("bw rd 44", d_resp_data, 32'h1000_AB11);
    tick();
    d_valid = 0;
    #1;
    chk("bw rd 40", d_resp_data, 32'hDEAD_BEEF);
    tick();
    chk("bw d_rv off", 32'(d_resp_valid), 0);

    // async reset mid-lock with response pending
    i_valid = 1; i_addr = 32'h10;
    d_valid = 1; d_addr = 32'h48; d_lock = 1;
    #1;
    chk("ar d_ready", 32'(d_ready), 1);
    tick();
    #1;
    chk("ar state", 32'(dut.state), 32'(LOCKED));
    chk("ar d_rv", 32'(d_resp_valid), 1);
    chk("ar d_ready2", 32'(d_ready), 1);
    #2;
    reset = 1;
    #1;
    all_zero("ar");
    chk("ar state rst", 32'(dut.state), 32'(ARB));
    i_valid = 0; d_valid = 0; d_lock = 0;
    tick();
    tick();
    reset = 0;
    #1;
    chk("ar post state", 32'(dut.state), 32'(ARB));
    chk("ar post cnt", 32'(dut.starve_cnt), 0);
    chk("ar post d_rv", 32'(d_resp_valid), 0);
    tick();
    chk("ar post d_rv2", 32'(d_resp_valid), 0);
    chk("ar post i_rv2", 32'(i_resp_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, synchronous 32-bit memory between the core's instruction-fetch and data-memory requesters. Data accesses have priority, and a starvation counter bounds fetch stalls. A lock mode gives the data side uninterrupted back-to-back accesses for read-modify-write. The block sits between the core's `imem`/`dmem` request ports and the unified memory macro.

## Interface
- `STARVE_LIMIT`, 4: maximum consecutive cycles a pending fetch request may lose arbitration; minimum value 1.
- `clk`  in  1  clock; all registers capture on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_valid` / `d_valid`  in  1  request valid, fetch (i) / data (d).
- `i_ready` / `d_ready`  out  1  request accepted this cycle.
- `i_addr` / `d_addr`  in  32  byte address.
- `i_write_en` / `d_write_en`  in  1  write request.
- `i_data_en` / `d_data_en`  in  4  byte enables.
- `i_data_i` / `d_data_i`  in  32  write data.
- `d_lock`  in  1  hold the memory for the data side after this access.
- `i_resp_valid` / `d_resp_valid`  out  1  response strobe.
- `i_resp_data` / `d_resp_data`  out  32  read data.
- `mem_addr`  out  32  address to memory.
- `mem_write_en`  out  1  write enable to memory.
- `mem_data_en`  out  4  byte enables to memory.
- `mem_data_i`  out  32  write data to memory.
- `mem_data_o`  in  32  read data, valid the cycle after the address is presented.

## Operation
**FSM states:** `ARB` and `LOCKED`. Reset enters `ARB`.

**Grant in `ARB`:**
- Only one requester valid: that requester wins.
- Both valid: `d` wins, unless `starve_cnt == STARVE_LIMIT`, in which case `i` wins.

**Grant in `LOCKED`:**
- Only `d` can win. `i_ready` is held at 0.

**State transitions:**
- An accepted `d` request with `d_lock=1` moves the FSM to `LOCKED`, or keeps it there.
- An accepted `d` request with `d_lock=0` returns the FSM to `ARB`.
- `d_lock` is ignored for write-only/read-only distinction; it applies to any `d` access.

**Handshake:**
- `x_ready` is combinational: 1 iff `x_valid` is high and x wins this cycle.
- A requester holds `valid` and its request fields stable until `ready` is seen.
- Dropping `valid` without a handshake is legal.

**Memory drive:**
- The winner's `addr`, `write_en`, `data_en` and `data_i` pass combinationally to the `mem_*` outputs.
- With no winner, all `mem_*` outputs are 0. In particular, `mem_data_en=0` and `mem_write_en=0`.

**Responses:**
- Every accepted request, read or write, produces exactly one `x_resp_valid` pulse, in the next cycle, on the winner's port.
- `x_resp_data = mem_data_o` while `x_resp_valid` is high, and 0 otherwise.
- For writes, `x_resp_data` is don't-care.

**Starvation counter (`starve_cnt`):**
- Increments when `i_valid` is high and `i` is not granted, saturating at `STARVE_LIMIT`.
- Clears when `i` is granted or when `i_valid` is low.
- Holds in `LOCKED`. Lock overrides starvation.

## Timing
- Accept in cycle N (`valid & ready` high at edge N); response in cycle N+1. Throughput is one access per cycle.
- Back-to-back grants to different requesters are legal. The response strobes alternate accordingly.
- Reset values, during and after reset until the first grant:
  - Outputs: `i_ready=d_ready=0`, `i_resp_valid=d_resp_valid=0`, `*_resp_data=0`, all `mem_*` outputs 0.
  - State: FSM `ARB`, `starve_cnt=0`.
- Reset asserted mid-lock or mid-response aborts that operation.
  - No response is issued for an access accepted in the cycle before reset.
  - The FSM returns to `ARB`.
- Only two registered response flags (`i` pending, `d` pending) are kept; at most one is set in any cycle.

## Structure
- `arb_state_t` (`ARB`, `LOCKED`) and the requester-id enum (`REQ_I`, `REQ_D`) belong in the shared `defines.sv`, alongside the pipeline control-word types.
- Implement as a single module with no sub-modules. The starvation counter and FSM are too small to split.

## Test plan
- **Single read:** `i_valid=1`, `i_addr=0x10`, `d_valid=0`. Required: `i_ready=1` and `mem_addr=0x10` in cycle N; `i_resp_valid=1` in N+1 with `i_resp_data` equal to the memory word at `0x10`.
- **Contention and starvation, `STARVE_LIMIT=4`:** `i_valid` and `d_valid` held high continuously. Required: `d` granted 4 cycles in a row, `i` granted on the 5th, then `starve_cnt=0` and `d` wins again.
- **Lock:**
  - `d` access `0x40`, `d_lock=1`, with `i_valid` high. Required: FSM enters `LOCKED`.
  - Then `d` write `0x40`, `d_lock=0`. Required: `i_ready=0` throughout `LOCKED`, even after the counter saturates; `i` is granted in the cycle after the unlocking write.
- **Byte write:** `d` write `0x44`, `d_data_en=4'b0010`, `data=0x0000AB00`. Required: a following read of `0x44` returns only byte 1 changed to `0xAB`; `d_resp_valid` pulses once per access.
- **Async reset:** reset asserted between edges during `LOCKED` with a response pending. Required: all outputs go to 0 immediately without waiting for a clock edge, and the FSM is in `ARB` after release.
- **Idle:** both `valid` low for 10 cycles. Required: `mem_write_en=0`, `mem_data_en=0`, no response pulses, `starve_cnt` stays 0.
